// File: rtl/tm1638_refresh.sv
// TM1638 refresh word generator: turns a snapshotted display image into the 11-word write sequence for the SPI FIFO.
// Optional TM1638_AUTO_REFRESH_EN adds a free-running periodic refresh request.
module tm1638_refresh
`ifdef TM1638_AUTO_REFRESH_EN
  #(parameter int unsigned REFRESH_PERIOD = 250000)
`endif
(
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Refresh,
  input  logic [63:0] i_Digits,
  input  logic [7:0]  i_Leds,
  input  logic [2:0]  i_Brightness,
  input  logic        i_Display_On,
  input  logic        i_FIFO_Full,
  output logic        o_Data_Valid,
  output logic [17:0] o_Data,
  output logic        o_Busy
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CMD_DATA = 3'd1;
  localparam logic [2:0] ST_CMD_ADDR = 3'd2;
  localparam logic [2:0] ST_PAIR     = 3'd3;
  localparam logic [2:0] ST_CMD_DISP = 3'd4;

  logic [2:0]  state, state_nx;
  logic [2:0]  pair_idx, pair_idx_nx;
  logic        pending, pending_nx;
  logic        snap_load;
  logic        push;
  logic        busy_nx;
  logic        req;
  logic [17:0] word_cur;
  logic [7:0]  disp_byte;

  logic [63:0] snap_digits;
  logic [7:0]  snap_leds;
  logic [2:0]  snap_bri;
  logic        snap_on;

`ifdef TM1638_AUTO_REFRESH_EN
  localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  logic [CNT_W-1:0] period_cnt;
  logic             auto_tick;

  assign auto_tick = (period_cnt == CNT_W'(REFRESH_PERIOD - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= auto_tick ? '0 : period_cnt + CNT_W'(1);
    end
  end

  assign req = i_Refresh | auto_tick;
`else
  assign req = i_Refresh;
`endif

  // Word for the current state, built only from the snapshot so image changes mid-sequence are invisible.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    word_cur  = '0;
    disp_byte = {4'b1000, snap_on, snap_bri};
    case (state)
      ST_CMD_DATA: word_cur = {1'b1, 1'b0, 8'h00, 8'h40};
      ST_CMD_ADDR: word_cur = {1'b0, 1'b0, 8'h00, 8'hC0};
      ST_PAIR:     word_cur = {pair_idx == 3'd7, 1'b1,
                               snap_digits[{pair_idx, 3'b000} +: 8],
                               7'b0, snap_leds[pair_idx]};
      ST_CMD_DISP: word_cur = {1'b1, 1'b0, 8'h00, disp_byte};
      default:     word_cur = '0;
    endcase
  end

  assign push = (state != ST_IDLE) && !i_FIFO_Full;

  always_comb begin
    state_nx    = state;
    pair_idx_nx = pair_idx;
    pending_nx  = pending;
    snap_load   = 1'b0;

    // Requests arriving while busy collapse into a single deferred refresh.
    if (state != ST_IDLE && req) pending_nx = 1'b1;

    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nx  = ST_CMD_DATA;
          snap_load = 1'b1;
        end
      end
      ST_CMD_DATA: if (push) state_nx = ST_CMD_ADDR;
      ST_CMD_ADDR: if (push) state_nx = ST_PAIR;
      ST_PAIR: begin
        if (push) begin
          pair_idx_nx = pair_idx + 3'd1;
          if (pair_idx == 3'd7) state_nx = ST_CMD_DISP;
        end
      end
      ST_CMD_DISP: begin
        if (push) begin
          if (pending || req) begin
            state_nx   = ST_CMD_DATA;
            snap_load  = 1'b1;
            pending_nx = 1'b0;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    busy_nx = (state_nx != ST_IDLE) || push;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= ST_IDLE;
      pair_idx     <= '0;
      pending      <= 1'b0;
      o_Data_Valid <= 1'b0;
      o_Data       <= '0;
      o_Busy       <= 1'b0;
      // NOTE: the image snapshot is plain flops, not a memory, so it is cleared with the rest of the state.
      snap_digits  <= '0;
      snap_leds    <= '0;
      snap_bri     <= '0;
      snap_on      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      state        <= state_nx;
      pair_idx     <= pair_idx_nx;
      pending      <= pending_nx;
      o_Data_Valid <= push;
      o_Busy       <= busy_nx;
      if (push) o_Data <= word_cur;
      if (snap_load) begin
        snap_digits <= i_Digits;
        snap_leds   <= i_Leds;
        snap_bri    <= i_Brightness;
        snap_on     <= i_Display_On;
      end
    end
  end

endmodule
